// File: rtl/id_ex_if.sv
// ID/EX issue-stage signal bundle: ID-side request, EX-side registered controls and redirect.
// The stage itself uses the slave modport; the upstream/downstream environment uses master.
interface id_ex_if;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc4;
    logic [31:0] id_rs_data;
    logic [31:0] id_rt_data;
    logic        ex_stall;
    logic        flush;
    logic        alu_zero;
    logic        ex_valid;
    logic [31:0] ex_entr1;
    logic [31:0] ex_entr2;
    logic [3:0]  ex_alu_ctrl;
    logic [4:0]  ex_rd;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic        ex_is_branch;
    logic        branch_taken;
    logic [31:0] branch_pc;
    logic        illegal;

    modport slave (
        input  id_valid, id_instr, id_pc4, id_rs_data, id_rt_data, ex_stall, flush, alu_zero,
        output id_ready, ex_valid, ex_entr1, ex_entr2, ex_alu_ctrl, ex_rd, ex_reg_write,
               ex_mem_read, ex_mem_write, ex_is_branch, branch_taken, branch_pc, illegal
    );

    modport master (
        output id_valid, id_instr, id_pc4, id_rs_data, id_rt_data, ex_stall, flush, alu_zero,
        input  id_ready, ex_valid, ex_entr1, ex_entr2, ex_alu_ctrl, ex_rd, ex_reg_write,
               ex_mem_read, ex_mem_write, ex_is_branch, branch_taken, branch_pc, illegal
    );
endinterface

// File: rtl/id_ex_issue_stage.sv
// ID/EX stage: decodes instructions into ALU controls/operands, registers them for EX and
// resolves beq/bne/bgez from the EX zero flag with a one-cycle redirect and wrong-path squash.
module id_ex_issue_stage #(
    parameter int unsigned DATA_W       = 32,
    parameter bit          ILLEGAL_TRAP = 1'b1
) (
    input logic    clk,
    input logic    rst_n,
    id_ex_if.slave bus
);

    typedef enum logic [3:0] {
        AluAdd  = 4'b0000,
        AluSub  = 4'b0001,
        AluAnd  = 4'b0010,
        AluNor  = 4'b0011,
        AluOr   = 4'b0100,
        AluSlt  = 4'b0101,
        AluBeq  = 4'b0110,
        AluBne  = 4'b0111,
        AluBgez = 4'b1111
    } alu_op_e;

    logic [31:0]       instr;
    logic [5:0]        op;
    logic [5:0]        funct;
    logic [4:0]        rt_f;
    logic [4:0]        rd_f;
    logic [15:0]       imm;
    logic [DATA_W-1:0] imm_sext;
    logic [DATA_W-1:0] imm_zext;
    logic              unused_instr_bits;

    assign instr             = bus.id_instr;
    assign op                = instr[31:26];
    assign rt_f              = instr[20:16];
    assign rd_f              = instr[15:11];
    assign funct             = instr[5:0];
    assign imm               = instr[15:0];
    assign imm_sext          = {{(DATA_W-16){imm[15]}}, imm};
    assign imm_zext          = {{(DATA_W-16){1'b0}}, imm};
    assign unused_instr_bits = ^{instr[25:21], instr[10:6]};

    logic              dec_legal;
    alu_op_e           dec_ctrl;
    logic [DATA_W-1:0] dec_entr2;
    logic [4:0]        dec_rd;
    logic              dec_reg_write;
    logic              dec_mem_read;
    logic              dec_mem_write;
    logic              dec_branch;

    always_comb begin
        dec_legal     = 1'b1;
        dec_ctrl      = AluAdd;
        dec_entr2     = bus.id_rt_data;
        dec_rd        = 5'd0;
        dec_reg_write = 1'b0;
        dec_mem_read  = 1'b0;
        dec_mem_write = 1'b0;
        dec_branch    = 1'b0;
        unique case (op)
            6'b000000: begin
                dec_rd        = rd_f;
                dec_reg_write = 1'b1;
                unique case (funct)
                    6'b100000: dec_ctrl = AluAdd;
                    6'b100010: dec_ctrl = AluSub;
                    6'b100100: dec_ctrl = AluAnd;
                    6'b100101: dec_ctrl = AluOr;
                    6'b100111: dec_ctrl = AluNor;
                    6'b101010: dec_ctrl = AluSlt;
                    default:   dec_legal = 1'b0;
                endcase
            end
            6'b001000: begin
                dec_entr2     = imm_sext;
                dec_rd        = rt_f;
                dec_reg_write = 1'b1;
            end
            6'b001010: begin
                dec_ctrl      = AluSlt;
                dec_entr2     = imm_sext;
                dec_rd        = rt_f;
                dec_reg_write = 1'b1;
            end
            6'b001100: begin
                dec_ctrl      = AluAnd;
                dec_entr2     = imm_zext;
                dec_rd        = rt_f;
                dec_reg_write = 1'b1;
            end
            6'b001101: begin
                dec_ctrl      = AluOr;
                dec_entr2     = imm_zext;
                dec_rd        = rt_f;
                dec_reg_write = 1'b1;
            end
            6'b100011: begin
                dec_entr2     = imm_sext;
                dec_rd        = rt_f;
                dec_reg_write = 1'b1;
                dec_mem_read  = 1'b1;
            end
            6'b101011: begin
                dec_entr2     = imm_sext;
                dec_mem_write = 1'b1;
            end
            6'b000100: begin
                dec_ctrl   = AluBeq;
                dec_branch = 1'b1;
            end
            6'b000101: begin
                dec_ctrl   = AluBne;
                dec_branch = 1'b1;
            end
            6'b000001: begin
                dec_ctrl   = AluBgez;
                dec_entr2  = '0;
                dec_branch = 1'b1;
                dec_legal  = (rt_f == 5'b00001);
            end
            default: dec_legal = 1'b0;
        endcase
    end

    logic              ex_valid_q, ex_valid_d;
    logic [DATA_W-1:0] entr1_q, entr1_d;
    logic [DATA_W-1:0] entr2_q, entr2_d;
    alu_op_e           ctrl_q, ctrl_d;
    logic [4:0]        rd_q, rd_d;
    logic              reg_write_q, reg_write_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic              is_branch_q, is_branch_d;
    logic [DATA_W-1:0] target_q, target_d;
    logic              taken_q, taken_d;
    logic [DATA_W-1:0] branch_pc_q, branch_pc_d;
    logic              illegal_q, illegal_d;
    logic              taken;

    // Resolution uses the zero flag of the branch currently sitting in EX.
    assign taken = ex_valid_q && is_branch_q && bus.alu_zero;

    always_comb begin
        ex_valid_d  = ex_valid_q;
        entr1_d     = entr1_q;
        entr2_d     = entr2_q;
        ctrl_d      = ctrl_q;
        rd_d        = rd_q;
        reg_write_d = reg_write_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        is_branch_d = is_branch_q;
        target_d    = target_q;
        taken_d     = 1'b0;
        branch_pc_d = branch_pc_q;
        illegal_d   = 1'b0;
        if (bus.flush || !bus.ex_stall) begin
            ex_valid_d  = 1'b0;
            entr1_d     = '0;
            entr2_d     = '0;
            ctrl_d      = AluAdd;
            rd_d        = 5'd0;
            reg_write_d = 1'b0;
            mem_read_d  = 1'b0;
            mem_write_d = 1'b0;
            is_branch_d = 1'b0;
        end
        if (!bus.flush && !bus.ex_stall) begin
            taken_d = taken;
            if (taken) begin
                branch_pc_d = target_q;
            end
            illegal_d = ILLEGAL_TRAP && bus.id_valid && !dec_legal && !taken;
            if (bus.id_valid && dec_legal && !taken) begin
                ex_valid_d  = 1'b1;
                entr1_d     = bus.id_rs_data;
                entr2_d     = dec_entr2;
                ctrl_d      = dec_ctrl;
                rd_d        = dec_rd;
                reg_write_d = dec_reg_write;
                mem_read_d  = dec_mem_read;
                mem_write_d = dec_mem_write;
                is_branch_d = dec_branch;
                target_d    = bus.id_pc4 + {imm_sext[DATA_W-3:0], 2'b00};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q  <= 1'b0;
            entr1_q     <= '0;
            entr2_q     <= '0;
            ctrl_q      <= AluAdd;
            rd_q        <= 5'd0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            is_branch_q <= 1'b0;
            target_q    <= '0;
            taken_q     <= 1'b0;
            branch_pc_q <= '0;
            illegal_q   <= 1'b0;
        end else begin
            ex_valid_q  <= ex_valid_d;
            entr1_q     <= entr1_d;
            entr2_q     <= entr2_d;
            ctrl_q      <= ctrl_d;
            rd_q        <= rd_d;
            reg_write_q <= reg_write_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            is_branch_q <= is_branch_d;
            target_q    <= target_d;
            taken_q     <= taken_d;
            branch_pc_q <= branch_pc_d;
            illegal_q   <= illegal_d;
        end
    end

    assign bus.id_ready     = rst_n && !bus.ex_stall;
    assign bus.ex_valid     = ex_valid_q;
    assign bus.ex_entr1     = entr1_q;
    assign bus.ex_entr2     = entr2_q;
    assign bus.ex_alu_ctrl  = ctrl_q;
    assign bus.ex_rd        = rd_q;
    assign bus.ex_reg_write = reg_write_q;
    assign bus.ex_mem_read  = mem_read_q;
    assign bus.ex_mem_write = mem_write_q;
    assign bus.ex_is_branch = is_branch_q;
    assign bus.branch_taken = taken_q;
    assign bus.branch_pc    = branch_pc_q;
    assign bus.illegal      = illegal_q;

endmodule

// File: tb/tb_id_ex_issue_stage.sv
// Scoreboard bench for id_ex_issue_stage: a reference model queues the expected EX state per
// clock edge, an independent monitor pops and compares after each edge.
module tb_id_ex_issue_stage;

    localparam bit TRAP = 1'b1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    id_ex_if bus ();

    id_ex_issue_stage #(
        .DATA_W      (32),
        .ILLEGAL_TRAP(TRAP)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct packed {
        logic        valid;
        logic        bt;
        logic        ill;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        br;
        logic [3:0]  ctrl;
        logic [4:0]  rd;
        logic [31:0] e1;
        logic [31:0] e2;
        logic [31:0] bpc;
    } exp_t;

    exp_t        q[$];
    exp_t        m;
    logic [31:0] m_tgt;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Instruction semantics straight from the decode table.
    function automatic exp_t ref_issue(input logic [31:0] ins, input logic [31:0] rs,
                                       input logic [31:0] rt, output logic ok);
        exp_t        f;
        logic [31:0] sx;
        logic [31:0] zx;
        sx = 32'($signed(ins[15:0]));
        zx = {16'h0, ins[15:0]};
        f = '0;
        f.valid = 1'b1;
        f.e1 = rs;
        ok = 1'b1;
        case (ins[31:26])
            6'd0: begin
                f.e2 = rt; f.rd = ins[15:11]; f.rw = 1'b1;
                case (ins[5:0])
                    6'h20: f.ctrl = 4'b0000;
                    6'h22: f.ctrl = 4'b0001;
                    6'h24: f.ctrl = 4'b0010;
                    6'h25: f.ctrl = 4'b0100;
                    6'h27: f.ctrl = 4'b0011;
                    6'h2a: f.ctrl = 4'b0101;
                    default: ok = 1'b0;
                endcase
            end
            6'h08: begin f.e2 = sx; f.ctrl = 4'b0000; f.rd = ins[20:16]; f.rw = 1'b1; end
            6'h0a: begin f.e2 = sx; f.ctrl = 4'b0101; f.rd = ins[20:16]; f.rw = 1'b1; end
            6'h0c: begin f.e2 = zx; f.ctrl = 4'b0010; f.rd = ins[20:16]; f.rw = 1'b1; end
            6'h0d: begin f.e2 = zx; f.ctrl = 4'b0100; f.rd = ins[20:16]; f.rw = 1'b1; end
            6'h23: begin
                f.e2 = sx; f.ctrl = 4'b0000; f.rd = ins[20:16]; f.rw = 1'b1; f.mr = 1'b1;
            end
            6'h2b: begin f.e2 = sx; f.ctrl = 4'b0000; f.mw = 1'b1; end
            6'h04: begin f.e2 = rt; f.ctrl = 4'b0110; f.br = 1'b1; end
            6'h05: begin f.e2 = rt; f.ctrl = 4'b0111; f.br = 1'b1; end
            6'h01: begin
                f.e2 = 32'h0; f.ctrl = 4'b1111; f.br = 1'b1;
                ok = (ins[20:16] == 5'd1);
            end
            default: ok = 1'b0;
        endcase
        return f;
    endfunction

    // Reference model: one expected snapshot per rising edge.
    always @(posedge clk or negedge rst_n) begin
        exp_t nxt;
        exp_t f;
        logic ok;
        logic taken;
        int   off;
        if (!rst_n) begin
            m = '0;
            m_tgt = 32'h0;
            if (clk) q.push_back(m);
        end else begin
            nxt = m;
            nxt.bt = 1'b0;
            nxt.ill = 1'b0;
            if (bus.flush) begin
                nxt.valid = 1'b0; nxt.rw = 1'b0; nxt.mr = 1'b0; nxt.mw = 1'b0; nxt.br = 1'b0;
            end else if (!bus.ex_stall) begin
                taken = m.valid && m.br && bus.alu_zero;
                f = ref_issue(bus.id_instr, bus.id_rs_data, bus.id_rt_data, ok);
                if (bus.id_valid && ok && !taken) begin
                    nxt = f;
                    off = $signed(bus.id_instr[15:0]);
                end else begin
                    nxt = '0;
                end
                nxt.bt = taken;
                nxt.bpc = taken ? m_tgt : m.bpc;
                nxt.ill = TRAP && bus.id_valid && !ok && !taken;
                if (bus.id_valid && ok && !taken) m_tgt = bus.id_pc4 + 32'(off * 4);
            end
            m = nxt;
            q.push_back(m);
        end
    end

    // Monitor: compares DUT EX state against the oldest queued expectation after each edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() == 0) begin
                chk("scoreboard_empty", 32'(q.size()), 32'd1);
            end else begin
                e = q.pop_front();
                chk("ex_valid", 32'(bus.ex_valid), 32'(e.valid));
                chk("branch_taken", 32'(bus.branch_taken), 32'(e.bt));
                chk("illegal", 32'(bus.illegal), 32'(e.ill));
                chk("ex_reg_write", 32'(bus.ex_reg_write), 32'(e.rw));
                chk("ex_mem_read", 32'(bus.ex_mem_read), 32'(e.mr));
                chk("ex_mem_write", 32'(bus.ex_mem_write), 32'(e.mw));
                chk("ex_is_branch", 32'(bus.ex_is_branch), 32'(e.br));
                if (e.valid) begin
                    chk("ex_entr1", bus.ex_entr1, e.e1);
                    chk("ex_entr2", bus.ex_entr2, e.e2);
                    chk("ex_alu_ctrl", 32'(bus.ex_alu_ctrl), 32'(e.ctrl));
                    if (e.rw) chk("ex_rd", 32'(bus.ex_rd), 32'(e.rd));
                end
                if (e.bt) chk("branch_pc", bus.branch_pc, e.bpc);
            end
        end
    end

    task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc4,
                        input logic [31:0] rs, input logic [31:0] rt, input logic stall,
                        input logic fl, input logic zero);
        @(negedge clk);
        bus.id_valid   = v;
        bus.id_instr   = ins;
        bus.id_pc4     = pc4;
        bus.id_rs_data = rs;
        bus.id_rt_data = rt;
        bus.ex_stall   = stall;
        bus.flush      = fl;
        bus.alu_zero   = zero;
        #1;
        chk("id_ready", 32'(bus.id_ready), 32'(rst_n && !stall));
    endtask

    task automatic idle();
        step(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic async_reset_check();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_ex_valid", 32'(bus.ex_valid), 32'h0);
        chk("rst_branch_taken", 32'(bus.branch_taken), 32'h0);
        chk("rst_illegal", 32'(bus.illegal), 32'h0);
        chk("rst_entr1", bus.ex_entr1, 32'h0);
        chk("rst_entr2", bus.ex_entr2, 32'h0);
        chk("rst_ctrl", 32'(bus.ex_alu_ctrl), 32'h0);
        chk("rst_rd", 32'(bus.ex_rd), 32'h0);
        chk("rst_ctrl_bits", 32'({bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write,
                                  bus.ex_is_branch}), 32'h0);
        chk("rst_branch_pc", bus.branch_pc, 32'h0);
        chk("rst_id_ready", 32'(bus.id_ready), 32'h0);
        idle();
        idle();
        rst_n = 1'b1;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [5:0] fl[6];
        logic [4:0] rs;
        logic [4:0] rt;
        logic [15:0] imm;
        fl = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2a};
        rs  = 5'($urandom);
        rt  = 5'($urandom);
        imm = 16'($urandom);
        case ($urandom_range(0, 12))
            0:  return {6'h00, rs, rt, imm[15:6], fl[$urandom_range(0, 5)]};
            1:  return {6'h00, rs, rt, imm};
            2:  return {6'h08, rs, rt, imm};
            3:  return {6'h0a, rs, rt, imm};
            4:  return {6'h0c, rs, rt, imm};
            5:  return {6'h0d, rs, rt, imm};
            6:  return {6'h23, rs, rt, imm};
            7:  return {6'h2b, rs, rt, imm};
            8:  return {6'h04, rs, rt, imm};
            9:  return {6'h05, rs, rt, imm};
            10: return {6'h01, rs, 5'd1, imm};
            11: return {6'h01, rs, rt, imm};
            default: return $urandom;
        endcase
    endfunction

    initial begin
        bus.id_valid = 1'b0; bus.id_instr = 32'h0; bus.id_pc4 = 32'h0; bus.id_rs_data = 32'h0;
        bus.id_rt_data = 32'h0; bus.ex_stall = 1'b0; bus.flush = 1'b0; bus.alu_zero = 1'b0;
        repeat (3) idle();
        rst_n = 1'b1;

        // add $3,$1,$2; andi/addi with 0xFFFF immediate
        step(1, 32'h00221820, 32'h100, 32'd5, 32'd7, 0, 0, 0);
        step(1, 32'h3022FFFF, 32'h104, 32'h12345678, 32'h0, 0, 0, 0);
        step(1, 32'h2022FFFF, 32'h108, 32'h12345678, 32'h0, 0, 0, 0);
        // beq taken: following add squashed, redirect to 0x114
        step(1, 32'h10220004, 32'h104, 32'd9, 32'd9, 0, 0, 0);
        step(1, 32'h00221820, 32'h108, 32'd1, 32'd2, 0, 0, 1);
        idle();
        // beq not taken: following add issues
        step(1, 32'h10220004, 32'h104, 32'd9, 32'd8, 0, 0, 0);
        step(1, 32'h00221820, 32'h108, 32'd1, 32'd2, 0, 0, 0);
        // stalled branch with zero=1 resolves only when the stall drops
        step(1, 32'h10220004, 32'h200, 32'd3, 32'd3, 0, 0, 0);
        repeat (3) step(1, 32'h00221820, 32'h204, 32'd1, 32'd2, 1, 0, 1);
        step(1, 32'h00221820, 32'h204, 32'd1, 32'd2, 0, 0, 1);
        idle();
        // illegal R-type funct, then the same under flush
        step(1, 32'h0000003F, 32'h300, 32'd1, 32'd2, 0, 0, 0);
        idle();
        step(1, 32'h0000003F, 32'h304, 32'd1, 32'd2, 0, 1, 0);
        idle();
        // bgez with negative offset, lw, sw
        step(1, 32'h0421FFFE, 32'h400, 32'd4, 32'd0, 0, 0, 0);
        step(1, 32'h8C430010, 32'h404, 32'd4, 32'd0, 0, 0, 1);
        step(1, 32'hAC43FFF0, 32'h408, 32'd4, 32'd6, 0, 0, 0);
        // asynchronous reset while a redirect pulse is live, then while ex_valid is live
        step(1, 32'h10220004, 32'h104, 32'd9, 32'd9, 0, 0, 0);
        step(1, 32'h00221820, 32'h108, 32'd1, 32'd2, 0, 0, 1);
        async_reset_check();
        step(1, 32'h00221820, 32'h100, 32'd5, 32'd7, 0, 0, 0);
        async_reset_check();
        step(1, 32'h00221820, 32'h100, 32'd11, 32'd13, 0, 0, 0);

        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 9) < 8, rand_instr(), $urandom, $urandom, $urandom,
                 $urandom_range(0, 9) < 2, $urandom_range(0, 19) == 0, 1'($urandom));
        end
        idle();
        idle();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, expected finish before 200000");
        $fatal(1);
    end

endmodule

// File: doc/id_ex_issue_stage.md
Name: id_ex_issue_stage

Overview:
ID/EX pipeline stage that drives the ALU: decodes each instruction into the 4-bit ALU operation code, selects and extends operands, and registers them toward the EX stage. It also samples the ALU zero flag back from EX to resolve beq/bne/bgez, issuing a one-cycle redirect and squashing the wrong-path instruction. It sits between the register-file read in ID and the ALU in EX.

Parameters:
DATA_W, 32, operand/PC width; only 32 is supported.
ILLEGAL_TRAP, 1, 1 = pulse illegal on undecodable instruction; 0 = convert silently to bubble.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  ID holds an instruction
id_ready  out  1  stage accepts this cycle; combinational = rst_n && !ex_stall
id_instr  in  32  instruction word
id_pc4  in  32  PC+4 of instruction
id_rs_data  in  32  register rs value
id_rt_data  in  32  register rt value
ex_stall  in  1  downstream hazard, hold EX registers
flush  in  1  discard the instruction being captured and EX contents
alu_zero  in  1  ALU zero flag for instruction currently in EX
ex_valid  out  1  EX registers hold a live instruction
ex_entr1  out  32  ALU operand 1
ex_entr2  out  32  ALU operand 2
ex_alu_ctrl  out  4  ALU operation code
ex_rd  out  5  destination register
ex_reg_write  out  1  writes register file
ex_mem_read  out  1  load
ex_mem_write  out  1  store
ex_is_branch  out  1  EX instruction is a branch
branch_taken  out  1  one-cycle redirect pulse
branch_pc  out  32  redirect target, valid with branch_taken
illegal  out  1  one-cycle undecodable-instruction pulse

Behaviour:
- Reset (async, rst_n=0): every registered output = 0 immediately; id_ready=0.
- ALU codes: ADD 0000, SUB 0001, AND 0010, NOR 0011, OR 0100, SLT 0101, BEQ 0110, BNE 0111, BGEZ 1111.
- Decode table, entr1 = rs in all cases:
  - R-type (op 000000), entr2=rt, rd=instr[15:11], reg_write=1:
    - funct 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 100111 NOR, 101010 SLT.
  - I-type ALU ops, rd=rt field, reg_write=1:
    - addi 001000 ADD sign-ext.
    - slti 001010 SLT sign-ext.
    - andi 001100 AND zero-ext.
    - ori 001101 OR zero-ext.
  - Memory ops, both sign-ext, ADD:
    - lw 100011: mem_read=1, reg_write=1, rd=rt.
    - sw 101011: mem_write=1.
  - Branches, is_branch=1, rd=0, no writes:
    - beq 000100: entr2=rt, BEQ.
    - bne 000101: entr2=rt, BNE.
    - bgez (op 000001, rt=00001): entr2=0, BGEZ.
  - Anything else is illegal.
- Latency: 1 cycle. Capture occurs on the edge where id_valid && !ex_stall && !flush && no taken-branch squash; ex_valid<=1 with decoded fields.
- Branch target: computed at capture as id_pc4 + (sign-ext imm << 2), modulo 2^32; held internally with the EX entry.
- Bubble: on an advancing edge with id_valid=0, ex_valid<=0 and all control bits <=0.
- Stall (ex_stall=1): all EX registers hold; alu_zero ignored; branch_taken<=0.
- Branch resolution: on an advancing edge with ex_valid && ex_is_branch && alu_zero=1:
  - branch_taken<=1, branch_pc<=target.
  - The instruction captured on that same edge is squashed (ex_valid<=0).
  - A not-taken branch produces branch_taken<=0 and no squash.
- flush=1: ex_valid<=0 and all controls <=0; overrides stall and suppresses branch_taken on that edge.
- Illegal instruction: becomes a bubble; illegal<=ILLEGAL_TRAP for exactly one cycle. No pulse when the illegal instruction is itself squashed or flushed.
- branch_taken and illegal are single-cycle pulses and clear on the next edge.

Test Plan:
- add $3,$1,$2 (0x00221820), rs=5, rt=7, id_valid=1 -> next cycle ex_valid=1, entr1=5, entr2=7, alu_ctrl=0000, rd=3, reg_write=1.
- andi with imm 0xFFFF, rs=0x12345678 -> entr2=0x0000FFFF, ctrl 0010. addi with imm 0xFFFF -> entr2=0xFFFFFFFF, ctrl 0000.
- beq $1,$2,4 (0x10220004), pc4=0x104 -> entry ctrl 0110. With alu_zero=1 on the next edge: branch_taken=1 for one cycle, branch_pc=0x114, the following instruction's ex_valid=0. With alu_zero=0: no pulse, and the following instruction is issued.
- ex_stall=1 for 3 cycles with a branch in EX and alu_zero=1 -> id_ready=0, EX outputs unchanged, branch_taken stays 0 until the stall releases, then pulses once.
- R-type funct 111111 -> ex_valid=0, illegal high for exactly 1 cycle. Repeat with flush=1 -> no pulse.
- rst_n dropped mid-cycle while branch_taken=1 and ex_valid=1 -> all outputs 0 immediately without a clock edge. After release, the first capture behaves as normal.
